regfile_write_arbiter: RTL and testbench

Shares the single write port of the 32x64 register file between two writeback producers: the ALU and the load unit. Each producer has a valid/ready handshake into a small private FIFO. A round-robin arbiter drains the FIFOs one entry per cycle onto the registered write port (addressw/writeData/writeEn). A pending-write vector is exported so decode can stall on RAW hazards against not-yet-committed writes.

---
 rtl/regfile_write_arbiter.sv | 165 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-producer writeback arbiter for the 32x64 register file.
// ALU and load unit each feed a small private FIFO; a round-robin
// arbiter drains one head per cycle onto the registered write port.
// Index 0 is the ALU path, index 1 is the load path throughout.

module regfile_write_arbiter_fifo #(
    parameter int DEPTH      = 32,
    parameter int BITS       = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_addr,
    input  logic [BITS-1:0]  in_data,
    input  logic             pop,
    output logic [AW-1:0]    head_addr,
    output logic [BITS-1:0]  head_data,
    output logic             nonempty,
    output logic [DEPTH-1:0] pend
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [FIFO_DEPTH-1:0][AW-1:0]   addr_mem;
    logic [FIFO_DEPTH-1:0][BITS-1:0] data_mem;
    logic [PW-1:0]                   wr_ptr, rd_ptr;
    logic [CW-1:0]                   count;
    logic                            push;
    logic [PW-1:0]                   offs;

    // Ready comes purely from the registered count, so a full FIFO never
    // accepts even if its head is leaving on the same edge.
    assign in_ready  = (count < CW'(FIFO_DEPTH));
    // Writes to x0 complete the handshake but are dropped here.
    assign push      = in_valid && in_ready && (in_addr != '0);
    assign nonempty  = (count != '0);
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Entry storage; contents only matter while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= in_addr;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // Circular pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // One-hot of every live entry's destination; a slot is live when its
    // distance from the read pointer is below the count.
    always_comb begin
        pend = '0;
        offs = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            offs = PW'(i) - rd_ptr;
            if (CW'(offs) < count) pend[addr_mem[i]] = 1'b1;
        end
    end
endmodule

module regfile_write_arbiter #(
    parameter int DEPTH      = 32,
    parameter int BITS       = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [$clog2(DEPTH)-1:0] alu_addr,
    input  logic [BITS-1:0]          alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [$clog2(DEPTH)-1:0] mem_addr,
    input  logic [BITS-1:0]          mem_data,
    output logic [$clog2(DEPTH)-1:0] addressw,
    output logic [BITS-1:0]          writeData,
    output logic                     writeEn,
    output logic [DEPTH-1:0]         pending,
    output logic                     idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int NR = 2;

    logic [NR-1:0]             req_valid, req_ready, ne, grant;
    logic [NR-1:0][AW-1:0]     req_addr, head_addr;
    logic [NR-1:0][BITS-1:0]   req_data, head_data;
    logic [NR-1:0][DEPTH-1:0]  pend;
    logic                      last_mem;

    assign req_valid = {mem_valid, alu_valid};
    assign req_addr  = {mem_addr, alu_addr};
    assign req_data  = {mem_data, alu_data};
    assign alu_ready = req_ready[0];
    assign mem_ready = req_ready[1];

    for (genvar r = 0; r < NR; r++) begin : g_req
        regfile_write_arbiter_fifo #(
            .DEPTH(DEPTH), .BITS(BITS), .FIFO_DEPTH(FIFO_DEPTH), .AW(AW)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (req_valid[r]),
            .in_ready  (req_ready[r]),
            .in_addr   (req_addr[r]),
            .in_data   (req_data[r]),
            .pop       (grant[r]),
            .head_addr (head_addr[r]),
            .head_data (head_data[r]),
            .nonempty  (ne[r]),
            .pend      (pend[r])
        );
    end

    // Round robin: on a tie the side not granted last wins; a lone
    // non-empty side always wins.
    assign grant[0] = ne[0] && (!ne[1] || last_mem);
    assign grant[1] = ne[1] && (!ne[0] || !last_mem);

    // Registered write port plus arbiter history. last_mem resets high so
    // the ALU takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addressw  <= '0;
            writeData <= '0;
            writeEn   <= 1'b0;
            last_mem  <= 1'b1;
        end else begin
            writeEn <= |grant;
            if (|grant) begin
                last_mem  <= grant[1];
                addressw  <= grant[1] ? head_addr[1] : head_addr[0];
                writeData <= grant[1] ? head_data[1] : head_data[0];
            end
        end
    end

    // Hazard vector: queued entries plus the in-flight write port.
    always_comb begin
        pending = pend[0] | pend[1];
        if (writeEn) pending[addressw] = 1'b1;
        pending[0] = 1'b0;
    end

    assign idle = !ne[0] && !ne[1] && !writeEn;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single write,
// contention/alternation, backpressure, x0 discard, push/pop at count 1,
// reset mid-traffic.

module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_addr, mem_addr, addressw;
    logic [63:0] alu_data, mem_data, writeData;
    logic        writeEn, idle;
    logic [31:0] pending;

    int checks = 0;
    int failures = 0;

    regfile_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .addressw(addressw), .writeData(writeData), .writeEn(writeEn),
        .pending(pending), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int ai, mi, aw, mw, cyc;
        bit fa, fm, saw_bp;

        rst_n = 1'b0;
        alu_valid = 0; mem_valid = 0;
        alu_addr = 0; mem_addr = 0; alu_data = 0; mem_data = 0;
        #2;
        check("rst_writeEn", writeEn, 0);
        check("rst_addressw", addressw, 0);
        check("rst_writeData", writeData, 0);
        check("rst_pending", pending, 0);
        check("rst_idle", idle, 1);
        check("rst_ready", {alu_ready, mem_ready}, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;

        // Single ALU write
        alu_valid = 1; alu_addr = 5; alu_data = 64'h1234;
        tick();
        alu_valid = 0;
        check("single_e0_we", writeEn, 0);
        check("single_e0_pend", pending, 32'h1 << 5);
        check("single_e0_idle", idle, 0);
        tick();
        check("single_e1_we", writeEn, 1);
        check("single_e1_addr", addressw, 5);
        check("single_e1_data", writeData, 64'h1234);
        check("single_e1_pend", pending, 32'h1 << 5);
        tick();
        check("single_e2_we", writeEn, 0);
        check("single_e2_pend", pending, 0);
        check("single_e2_idle", idle, 1);

        // Contention from a fresh reset: ALU wins the first tie
        do_reset();
        alu_valid = 1; alu_addr = 3; alu_data = 64'hA;
        mem_valid = 1; mem_addr = 4; mem_data = 64'hB;
        tick();
        alu_valid = 0; mem_valid = 0;
        check("cont_pend", pending, (32'h1 << 3) | (32'h1 << 4));
        tick();
        check("cont_w1", {writeEn, 3'b0, addressw, writeData}, {1'b1, 3'b0, 5'd3, 64'hA});
        tick();
        check("cont_w2", {writeEn, 3'b0, addressw, writeData}, {1'b1, 3'b0, 5'd4, 64'hB});
        tick();
        check("cont_done", writeEn, 0);

        // Refill both: last grant was load, so ALU/load/ALU/load
        alu_valid = 1; alu_addr = 6; alu_data = 64'h1;
        mem_valid = 1; mem_addr = 8; mem_data = 64'h3;
        tick();
        alu_addr = 7; alu_data = 64'h2;
        mem_addr = 9; mem_data = 64'h4;
        tick();
        alu_valid = 0; mem_valid = 0;
        check("alt_1", {addressw, writeData}, {5'd6, 64'h1});
        tick();
        check("alt_2", {addressw, writeData}, {5'd8, 64'h3});
        tick();
        check("alt_3", {addressw, writeData}, {5'd7, 64'h2});
        tick();
        check("alt_4", {writeEn, addressw, writeData}, {1'b1, 5'd9, 64'h4});
        tick();
        check("alt_done", {writeEn, idle}, 2'b01);

        // Backpressure: both stream 4 requests
        do_reset();
        ai = 0; mi = 0; aw = 0; mw = 0; saw_bp = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            alu_valid = (ai < 4); alu_addr = 5'(10 + ai); alu_data = 64'hA0 + 64'(ai);
            mem_valid = (mi < 4); mem_addr = 5'(20 + mi); mem_data = 64'hB0 + 64'(mi);
            fa = alu_valid && alu_ready;
            fm = mem_valid && mem_ready;
            tick();
            if (fa) ai++;
            if (fm) mi++;
            if (writeEn) begin
                if (addressw >= 5'd20) begin
                    check("bp_mem_addr", addressw, 64'(20 + mw));
                    check("bp_mem_data", writeData, 64'hB0 + 64'(mw));
                    mw++;
                end else begin
                    check("bp_alu_addr", addressw, 64'(10 + aw));
                    check("bp_alu_data", writeData, 64'hA0 + 64'(aw));
                    aw++;
                end
            end
            if (!mem_ready && !saw_bp) begin
                saw_bp = 1;
                check("bp_count_at_drop", 64'(mi - mw), 2);
            end
            if (ai == 4 && mi == 4 && idle) break;
        end
        alu_valid = 0; mem_valid = 0;
        check("bp_saw_not_ready", saw_bp, 1);
        check("bp_mem_writes", mw, 4);
        check("bp_alu_writes", aw, 4);
        check("bp_idle", idle, 1);

        // x0 discard
        check("x0_ready_before", alu_ready, 1);
        alu_valid = 1; alu_addr = 0; alu_data = 64'hFFFF;
        tick();
        alu_valid = 0;
        check("x0_ready_after", alu_ready, 1);
        for (int k = 0; k < 3; k++) begin
            check("x0_quiet", {writeEn, idle, pending}, {1'b0, 1'b1, 32'h0});
            tick();
        end

        // Push and pop on the same edge at count 1
        alu_valid = 1; alu_addr = 1; alu_data = 64'h11;
        tick();
        alu_addr = 2; alu_data = 64'h22;
        tick();
        alu_valid = 0;
        check("pp_w1", {writeEn, addressw, writeData}, {1'b1, 5'd1, 64'h11});
        check("pp_pend", pending, (32'h1 << 1) | (32'h1 << 2));
        check("pp_ready", alu_ready, 1);
        tick();
        check("pp_w2", {writeEn, addressw, writeData}, {1'b1, 5'd2, 64'h22});
        check("pp_pend2", pending, 32'h1 << 2);
        tick();
        check("pp_done", {writeEn, idle}, 2'b01);

        // Reset mid-traffic
        alu_valid = 1; alu_addr = 12; alu_data = 64'h5;
        mem_valid = 1; mem_addr = 13; mem_data = 64'h6;
        tick();
        alu_addr = 14; mem_addr = 15;
        tick();
        alu_addr = 16; mem_addr = 17;
        tick();
        check("mid_busy", idle, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", writeEn, 0);
        check("mid_rst_pend", pending, 0);
        check("mid_rst_ready", {alu_ready, mem_ready}, 2'b11);
        check("mid_rst_idle", idle, 1);
        alu_valid = 0; mem_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("mid_post_quiet", {writeEn, idle}, 2'b01);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
